// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed streaming FIFO controller.
//   OUT_BUF_DEPTH : depth of the prefetch output buffer behind the SRAM read port.
//   credit_t      : width for the read-issue credit arithmetic
//                   (ob_cnt + rd_pending + 1 peaks at 4).
package sram_fifo_pkg;

  localparam int unsigned OUT_BUF_DEPTH = 2;

  typedef logic [2:0] credit_t;

endpackage

// File: rtl/sram_fifo_output_buffer.sv
// Two-entry register FIFO that catches SRAM read data and presents the read-stream head.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   fill_i        : write fill_data_i at the end of this cycle
//   fill_data_i   : word returned from the SRAM
//   pop_i         : head consumed this cycle
//   head_o        : current head word (entry 0)
//   cnt_o         : number of words held (0..2)
module sram_fifo_output_buffer
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] fill_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       cnt_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({fill_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = fill_data_i;
        else               ent1_d = fill_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = fill_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = fill_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = ent0_q;
  assign cnt_o  = cnt_q;

  // The read-issue credit rule upstream must keep these from ever firing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fill_i && !pop_i && (cnt_q == 2'(OUT_BUF_DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && (cnt_q == 2'd0)));

endmodule

// File: rtl/sram_stream_fifo_ctrl.sv
// Streaming FIFO controller in front of / behind a double-ported type-T SRAM macro.
// A valid/ready write stream is written through the WEB/AA/D/M port; words are read
// through REB/AB and the 1-cycle registered Q is caught by a 2-entry prefetch buffer
// that drives the valid/ready read stream. Total capacity is NUM_ROWS + 2.
// Ports:
//   CLK, RST                     : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data       : write stream
//   m_valid/m_ready/m_data       : read stream
//   count                        : words held (SRAM + in flight + output buffer)
//   sram_REB/WEB/AA/AB/D/M/Q     : SRAM macro interface (enables active low)
module sram_stream_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned NUM_ROWS = 4096,
  localparam int unsigned AddressWidth = $clog2(NUM_ROWS),
  localparam int unsigned CountWidth   = $clog2(NUM_ROWS + 3)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic [CountWidth-1:0]   count,
  output logic                    sram_REB,
  output logic                    sram_WEB,
  output logic [AddressWidth-1:0] sram_AA,
  output logic [AddressWidth-1:0] sram_AB,
  output logic [WIDTH-1:0]        sram_D,
  output logic [WIDTH-1:0]        sram_M,
  input  logic [WIDTH-1:0]        sram_Q
);

  localparam int unsigned SramCntWidth = AddressWidth + 1;

  logic [AddressWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddressWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [SramCntWidth-1:0] sram_cnt_q, sram_cnt_d;
  logic                    rd_pending_q;
  logic [CountWidth-1:0]   count_q, count_d;
  logic [1:0]              ob_cnt;
  logic                    push, pop, issue;
  credit_t                 credit_need, credit_avail;

  // s_ready looks only at registered occupancy, so a read issued this cycle does
  // not free a slot until the next one; this also keeps AB off a word being written.
  assign s_ready = ~RST & (sram_cnt_q < SramCntWidth'(NUM_ROWS));
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Issue only if the word will have a buffer slot when it lands next cycle;
  // a pop this cycle frees one (combinational m_ready -> sram_REB path).
  assign credit_need  = credit_t'(ob_cnt) + credit_t'(rd_pending_q) + credit_t'(1);
  assign credit_avail = credit_t'(OUT_BUF_DEPTH) + credit_t'(pop);
  assign issue        = (sram_cnt_q != '0) && (credit_need <= credit_avail);

  always_comb begin
    wr_ptr_d   = push  ? wr_ptr_q + AddressWidth'(1) : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + AddressWidth'(1) : rd_ptr_q;
    sram_cnt_d = sram_cnt_q + SramCntWidth'(push) - SramCntWidth'(issue);
    count_d    = count_q + CountWidth'(push) - CountWidth'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sram_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      count_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sram_cnt_q   <= sram_cnt_d;
      rd_pending_q <= issue;
      count_q      <= count_d;
    end
  end

  sram_fifo_output_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .fill_i     (rd_pending_q),
    .fill_data_i(sram_Q),
    .pop_i      (pop),
    .head_o     (m_data),
    .cnt_o      (ob_cnt)
  );

  assign m_valid  = (ob_cnt != 2'd0);
  assign count    = count_q;
  assign sram_WEB = ~push;
  assign sram_AA  = wr_ptr_q;
  assign sram_D   = s_data;
  assign sram_M   = '0;
  assign sram_REB = ~issue;
  assign sram_AB  = rd_ptr_q;

endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
module tb_sram_stream_fifo_ctrl;

  localparam int unsigned W    = 16;
  localparam int unsigned Rows = 16;
  localparam int unsigned AW   = $clog2(Rows);
  localparam int unsigned CW   = $clog2(Rows + 3);
  localparam int unsigned Cap  = Rows + 2;

  logic          CLK, RST;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]  s_data, m_data;
  logic [CW-1:0] count;
  logic          sram_REB, sram_WEB;
  logic [AW-1:0] sram_AA, sram_AB;
  logic [W-1:0]  sram_D, sram_M, sram_Q;

  sram_stream_fifo_ctrl #(
    .WIDTH   (W),
    .NUM_ROWS(Rows)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count),
    .sram_REB(sram_REB),
    .sram_WEB(sram_WEB),
    .sram_AA (sram_AA),
    .sram_AB (sram_AB),
    .sram_D  (sram_D),
    .sram_M  (sram_M),
    .sram_Q  (sram_Q)
  );

  // Behavioural double-port SRAM with registered read data.
  logic [W-1:0] sram_mem [Rows];
  logic [W-1:0] sram_q_r;
  assign sram_Q = sram_q_r;
  always @(posedge CLK) begin
    if (!sram_WEB) sram_mem[sram_AA] <= sram_D & ~sram_M;
    if (!sram_REB) sram_q_r <= sram_mem[sram_AB];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  // Reference model: the FIFO is just an ordered queue of accepted words.
  logic [W-1:0] model_q[$];
  int           outstanding;  // reads issued but not yet popped
  int           n_pass, n_total;
  int           n_pops;
  logic [W-1:0] last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Caller has set inputs and let them settle; account for this cycle's handshakes,
  // advance one clock and land #1 after the edge.
  task automatic tick();
    logic push, pop;
    logic [W-1:0] exp;
    push = s_valid & s_ready;
    pop  = m_valid & m_ready;
    if (model_q.size() == 0) check("m_valid_empty", m_valid, 0);
    if (model_q.size() < Rows) check("s_ready_room", s_ready, 1);
    if (model_q.size() == Cap) check("s_ready_full", s_ready, 0);
    if (!sram_REB) outstanding++;
    if (pop) begin
      check("pop_nonempty", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        exp = model_q.pop_front();
        check("m_data", m_data, exp);
      end
      outstanding--;
      n_pops++;
      last_pop = m_data;
    end
    check("outstanding_le2", outstanding <= 2, 1);
    if (push) model_q.push_back(s_data);
    @(posedge CLK);
    #1;
    check("count", count, model_q.size());
  endtask

  initial begin
    int accepted, pushed;
    logic [3:0] pat;
    n_pass = 0; n_total = 0; outstanding = 0; n_pops = 0; last_pop = '0;
    RST = 1'b1; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b0;

    // Reset state, with s_valid asserted to show it is ignored.
    #12;
    check("rst_count", count, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_REB", sram_REB, 1);
    check("rst_WEB", sram_WEB, 1);
    s_valid = 1'b0;
    #10 RST = 1'b0;
    @(posedge CLK); #1;

    // Single word: m_valid first high three cycles after the push.
    s_valid = 1'b1; s_data = 16'h00A5; m_ready = 1'b1; #1;
    check("sw_mv_c0", m_valid, 0);
    tick();
    s_valid = 1'b0; #1;
    check("sw_mv_c1", m_valid, 0);
    tick();
    #1;
    check("sw_mv_c2", m_valid, 0);
    tick();
    #1;
    check("sw_mv_c3", m_valid, 1);
    check("sw_data_c3", m_data, 16'h00A5);
    tick();
    #1;
    check("sw_mv_c4", m_valid, 0);
    check("sw_count_c4", count, 0);

    // Streaming 0..999 at full rate.
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'b1; s_data = W'(i); m_ready = 1'b1; #1;
      if (i >= 1) check("stream_REB_low", sram_REB, 0);
      if (i >= 3) begin
        check("stream_m_valid", m_valid, 1);
        check("stream_m_data", m_data, 32'(i - 3));
      end
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin #1; tick(); end
    check("stream_drained", model_q.size(), 0);

    // Fill to full with the read side stalled.
    m_ready = 1'b0; s_valid = 1'b1; accepted = 0;
    for (int c = 0; c < 40; c++) begin
      s_data = W'($urandom); #1;
      if (!s_ready) break;
      accepted++;
      tick();
    end
    check("full_accepted", accepted, Cap);
    check("full_count", count, Cap);
    check("full_m_valid", m_valid, 1);
    s_valid = 1'b0; m_ready = 1'b1; #1;
    check("full_s_ready_pop_cycle", s_ready, 0);
    tick();
    m_ready = 1'b0; #1;
    check("full_s_ready_after", s_ready, 1);
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin #1; tick(); end
    #1; tick();
    check("full_drained", count, 0);

    // Random valid/ready with pointer wrap-around.
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 100; c++) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = W'($urandom);
      m_ready = 1'($urandom_range(0, 1)); #1;
      if (s_valid && s_ready) pushed++;
      tick();
    end
    check("wrap_pushed", pushed, 100);
    s_valid = 1'b0;
    for (int c = 0; c < 500 && model_q.size() != 0; c++) begin
      m_ready = 1'($urandom_range(0, 1)); #1; tick();
    end
    check("wrap_drained", model_q.size(), 0);

    // Backpressure pattern 1,0,0,1 with the SRAM kept non-empty.
    pat = 4'b1001;
    for (int c = 0; c < 60; c++) begin
      s_valid = 1'b1; s_data = W'($urandom); m_ready = pat[c % 4]; #1; tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 60 && model_q.size() != 0; c++) begin #1; tick(); end
    #1; tick();
    check("bp_drained", count, 0);

    // Mid-stream asynchronous reset with 7 words queued.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin s_data = W'(16'h0100 + c); #1; tick(); end
    s_valid = 1'b0;
    check("mr_count7", count, 7);
    #2 RST = 1'b1;
    #1;
    check("mr_m_valid", m_valid, 0);
    check("mr_count", count, 0);
    check("mr_s_ready", s_ready, 0);
    check("mr_REB", sram_REB, 1);
    model_q.delete(); outstanding = 0;
    @(posedge CLK); @(posedge CLK); #3 RST = 1'b0;
    @(posedge CLK); #1;
    n_pops = 0;
    s_valid = 1'b1; s_data = 16'h003C; m_ready = 1'b1; #1; tick();
    s_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin #1; tick(); end
    check("mr_pops", n_pops, 1);
    check("mr_data", last_pop, 16'h003C);
    check("mr_final_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
